// File: rtl/spi_ctl_master.sv
// spi_ctl_master: mode-0, MSB-first, 32-bit full-duplex SPI shift engine
// driven by the register file's start level, select and data fields.
module spi_ctl_master #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [1:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        sclk_o,
  output logic        mosi_o,
  input  logic        miso_i,
  output logic [3:0]  cs_n_o
);

  localparam logic [7:0] PH_LOAD = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_n;

  logic        start_d;
  logic        accept;
  logic        ph_zero;
  logic        last_bit;
  logic        active_n;
  logic [1:0]  sel_n;

  logic [7:0]  ph;
  logic [4:0]  bit_cnt;
  logic [31:0] tx_sh;
  logic [31:0] rx_sh;
  logic [31:0] dat_q;
  logic [1:0]  sel_q;
  logic        sclk_q;
  logic        busy_q;
  logic        done_q;
  logic [3:0]  cs_q;

  // A transfer starts only on a fresh rising start edge while idle.
  assign accept   = start_i & ~start_d
                  & (state == S_IDLE);
  assign ph_zero  = (ph == 8'd0);
  assign last_bit = ph_zero & sclk_q
                  & (bit_cnt == 5'd0);

  // Select used for the chip-select register: the live input on the
  // accepting edge, the latched copy for the rest of the transfer.
  assign sel_n    = accept ? sel_i : sel_q;
  assign active_n = (state_n == S_SETUP)
                  | (state_n == S_SHIFT)
                  | (state_n == S_HOLD);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_n = S_SETUP;
        end
      end
      S_SETUP: begin
        if (ph_zero) begin
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last_bit) begin
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ph_zero) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (!start_i) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Start edge detector; resets high so a held start is not a new edge.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      start_d <= 1'b1;
    end else begin
      start_d <= start_i;
    end
  end

  // Phase/bit counters, SCLK generation and the two shift registers.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      ph      <= 8'd0;
      bit_cnt <= 5'd0;
      tx_sh   <= 32'd0;
      rx_sh   <= 32'd0;
      sel_q   <= 2'd0;
      sclk_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            tx_sh   <= dat_i;
            sel_q   <= sel_i;
            bit_cnt <= 5'd31;
            ph      <= PH_LOAD;
          end
        end
        S_SETUP, S_HOLD: begin
          ph <= ph_zero ? PH_LOAD : ph - 8'd1;
        end
        S_SHIFT: begin
          if (ph_zero) begin
            ph <= PH_LOAD;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              rx_sh  <= {rx_sh[30:0], miso_i};
            end else begin
              sclk_q  <= 1'b0;
              tx_sh   <= {tx_sh[30:0], 1'b0};
              bit_cnt <= bit_cnt - 5'd1;
            end
          end else begin
            ph <= ph - 8'd1;
          end
        end
        default: begin
          sclk_q <= 1'b0;
        end
      endcase
    end
  end

  // Registered status, chip selects and received word toward the
  // register file, all derived from the next state.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cs_q   <= 4'hF;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dat_q  <= 32'd0;
    end else begin
      cs_q   <= active_n ? ~(4'b0001 << sel_n) : 4'hF;
      busy_q <= active_n;
      done_q <= (state_n == S_DONE);
      if ((state == S_HOLD) && ph_zero) begin
        dat_q <= rx_sh;
      end
    end
  end

  assign dat_o  = dat_q;
  assign done_o = done_q;
  assign busy_o = busy_q;
  assign sclk_o = sclk_q;
  assign mosi_o = tx_sh[31];
  assign cs_n_o = cs_q;

endmodule
